// File: rtl/rf_pkg.sv
// Shared sizes and requester identifiers for the register-file write scheduler.
package rf_pkg;

    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int NREG = 2 ** AW;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the register-file write port.
// Callers pass eligibility, which already folds in any blocking conditions.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic elig_alu,
    input  logic elig_ld,
    output logic gnt_alu,
    output logic gnt_ld
);

    req_e last_win;

    // Grant the single eligible requester, or the one that did not win last time.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_ld  = 1'b0;
        if (!reset) begin
            if (elig_alu && elig_ld) begin
                if (last_win == REQ_ALU) begin
                    gnt_ld = 1'b1;
                end else begin
                    gnt_alu = 1'b1;
                end
            end else begin
                gnt_alu = elig_alu;
                gnt_ld  = elig_ld;
            end
        end
    end

    // Remember the most recent winner; reset to LD so the ALU takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_win <= REQ_LD;
        end else if (gnt_alu) begin
            last_win <= REQ_ALU;
        end else if (gnt_ld) begin
            last_win <= REQ_LD;
        end
    end

endmodule

// File: rtl/rf_wr_sched.sv
// Register-file write scheduler: arbitrates ALU and load writebacks onto one
// write port, tracks registers reserved by in-flight loads, and reports hazards.
module rf_wr_sched
    import rf_pkg::*;
#(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_req,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_gnt,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_gnt,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic          hazA,
    output logic          hazB,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] dat_in,
    output logic          rsv_err
);

    localparam int NR = 2 ** AW;

    logic [NR-1:0] busy;
    logic [NR-1:0] busy_nxt;
    logic          alu_elig;
    logic          rsv_clash;
    logic          rsv_err_r;
    logic          wr_en_p1;
    logic [AW-1:0] wr_addr_p1;
    logic [DW-1:0] dat_in_p1;

    // An ALU write to a register still owned by a pending load must wait (WAW).
    assign alu_elig = alu_req & ~busy[alu_addr];

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .elig_alu (alu_elig),
        .elig_ld  (ld_req),
        .gnt_alu  (alu_gnt),
        .gnt_ld   (ld_gnt)
    );

    // Hazards read the registered scoreboard only; no same-cycle bypass.
    assign hazA = busy[rd_addrA];
    assign hazB = busy[rd_addrB];

    // Scoreboard next state: load grant clears, reservation sets, set applied last so it wins.
    always_comb begin
        busy_nxt = busy;
        if (ld_gnt) begin
            busy_nxt[ld_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // Reserving an already-busy register is an error unless a load frees it this cycle.
    assign rsv_clash = rsv_en & busy[rsv_addr] & ~(ld_gnt & (ld_addr == rsv_addr));

    // Scoreboard and sticky reservation-error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= '0;
            rsv_err_r <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (rsv_clash) begin
                rsv_err_r <= 1'b1;
            end
        end
    end

    // ---- stage p1: register-file write port, one cycle after the grant ----
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            dat_in_p1  <= '0;
        end else begin
            wr_en_p1 <= alu_gnt | ld_gnt;
            if (alu_gnt) begin
                wr_addr_p1 <= alu_addr;
                dat_in_p1  <= alu_data;
            end else if (ld_gnt) begin
                wr_addr_p1 <= ld_addr;
                dat_in_p1  <= ld_data;
            end
        end
    end

    assign wr_en   = wr_en_p1;
    assign wr_addr = wr_addr_p1;
    assign dat_in  = dat_in_p1;
    assign rsv_err = rsv_err_r;

endmodule
